alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares the single combinational miniRISC ALU between two requesters. Port 0 is the execute stage. Port 1 is an auxiliary multi-cycle sequencer, such as a multiply/branch-compare helper. Grants at most one operation per cycle and registers the result and flags back to the winning requester. Owns the architectural flag register {carry, zero, sign}. The ALU itself sits outside the block; the arbiter drives its operand and control inputs and samples its result and flag outputs.

Parameters:
WIDTH, 32, operand/result width
CTRL_W, 5, ALU control code width
MAX_WAIT, 4, cycles port 1 may be refused before it is force-granted; 0 disables aging

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  port 0 request
req0_ready  out  1  port 0 granted this cycle
req0_a  in  WIDTH  port 0 operand A
req0_b  in  WIDTH  port 0 operand B
req0_ctrl  in  CTRL_W  port 0 ALU control code
req0_flag_we  in  1  port 0 op updates flags_q
req1_valid  in  1  port 1 request
req1_ready  out  1  port 1 granted this cycle
req1_a  in  WIDTH  port 1 operand A
req1_b  in  WIDTH  port 1 operand B
req1_ctrl  in  CTRL_W  port 1 ALU control code
rsp0_valid  out  1  port 0 result valid (1-cycle pulse)
rsp0_result  out  WIDTH  port 0 result
rsp0_flags  out  3  port 0 flags {C,Z,S}
rsp1_valid  out  1  port 1 result valid (1-cycle pulse)
rsp1_result  out  WIDTH  port 1 result
rsp1_flags  out  3  port 1 flags {C,Z,S}
alu_a  out  WIDTH  to ALU A
alu_b  out  WIDTH  to ALU B
alu_ctrl  out  CTRL_W  to ALU controls
alu_result  in  WIDTH  from ALU result_final
alu_flags  in  3  from ALU flags
flags_q  out  3  architectural flag register {C,Z,S}

Behaviour:
- Reset (async, rst_n=0):
  - rsp0_valid, rsp1_valid = 0; rsp*_result = 0; rsp*_flags = 0; flags_q = 3'b000.
  - last_grant = 1, so port 0 wins the first contention.
  - wait_cnt = 0.
- Reset mid-operation: any in-flight response is dropped and no rsp_valid is issued after release.
- Handshake:
  - reqX_ready is combinational: reqX_ready = reqX_valid & grantX.
  - A transfer occurs when valid & ready are both high.
  - A requester holds valid and its payload stable until ready; it must not withdraw valid while waiting.
- Grant:
  - Only one valid: grant it.
  - Both valid: grant the port not in last_grant (round-robin).
  - Aging override: MAX_WAIT != 0 and wait_cnt == MAX_WAIT forces grant to port 1.
  - last_grant updates on every transfer.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) each cycle req1_valid=1 and req1_ready=0.
  - Clears on a port 1 transfer or when req1_valid=0.
  - With round-robin, aging only matters if the port 1 payload is refused repeatedly; it still must be implemented and tested.
- ALU drive:
  - Granted cycle: alu_a/alu_b/alu_ctrl come from the winner.
  - Idle cycle: all zero.
- Latency 1:
  - On the transfer edge, alu_result and alu_flags are captured into the winner's rsp registers, and its rsp_valid is set for exactly one cycle.
  - The loser's rsp registers hold their previous value.
  - Responses have no backpressure.
- Flags:
  - flags_q <= alu_flags at the edge of a port 0 transfer with req0_flag_we=1.
  - Port 1 never writes flags_q.
  - flags_q is otherwise held.
- Back-to-back: one transfer per cycle sustained; a port may win consecutive cycles when the other is idle.
- Control codes (5 bit) are passed through unmodified; the arbiter does not decode them except in the package constants used by the bench.

Decomposition:
- Package alu_arb_pkg:
  - ALU_ADD=5'b00000, ALU_AND=5'b00001, ALU_XOR=5'b00010, ALU_SHL=5'b00011, ALU_SHR=5'b00111, ALU_SRA=5'b01111, ALU_DIFF=5'b10000
  - Flag indices FLAG_C=2, FLAG_Z=1, FLAG_S=0
  - Port index constants PORT_EX=0, PORT_AUX=1
- Sub-module rr_arb2_aging holds last_grant, wait_cnt and the grant logic. It takes the two valids and returns grant0/grant1. The top level handles muxing, response registers and flags_q.

Test Plan:
1. Reset, then port 0 only: ALU_ADD a=5, b=7, flag_we=1.
   - req0_ready=1 in the same cycle.
   - Next cycle: rsp0_valid=1, rsp0_result=12, rsp0_flags=3'b000, flags_q=3'b000.
2. Port 0 ALU_XOR a=b=32'hA5A5A5A5, flag_we=1.
   - rsp0_result=0, rsp0_flags=3'b010, flags_q=3'b010.
   - Then a port 1 ALU_ADD 32'hFFFFFFFF+1 gives rsp1_flags=3'b110, and flags_q stays 3'b010.
3. Both valid for 4 cycles after reset:
   - Grants alternate 0,1,0,1.
   - rsp pulses alternate with one-cycle latency; alu_ctrl matches the granting port each cycle.
4. Bench overrides grant via force: port 0 held valid, port 1 refused 4 consecutive cycles (MAX_WAIT=4).
   - 5th cycle: req1_ready=1, req0_ready=0; wait_cnt then returns to 0.
5. Port 1 ALU_SHL a=1, b=4.
   - rsp1_result=16.
   - rst_n pulled low the cycle after transfer: rsp1_valid=0 immediately, all outputs zero, no rsp pulse after release.
6. Idle 3 cycles:
   - alu_a=alu_b=0, alu_ctrl=0, no rsp_valid, flags_q unchanged.

Source files
------------

// File: rtl/alu_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_arb_pkg
// Description : Shared constants for the miniRISC ALU arbiter: ALU control
//               codes, flag bit positions within {C,Z,S}, port indices and
//               a helper that sizes the port 1 aging counter.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_arb_pkg;

  // ALU control codes (passed through the arbiter untouched)
  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_AND  = 5'b00001;
  localparam logic [4:0] ALU_XOR  = 5'b00010;
  localparam logic [4:0] ALU_SHL  = 5'b00011;
  localparam logic [4:0] ALU_SHR  = 5'b00111;
  localparam logic [4:0] ALU_SRA  = 5'b01111;
  localparam logic [4:0] ALU_DIFF = 5'b10000;

  // Bit positions inside a {C,Z,S} flag vector
  localparam int FLAG_C = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_S = 0;

  // Port indices, also the encoding of the last-grant register
  localparam logic PORT_EX  = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  // Width of a counter able to hold 0..max_wait (at least one bit)
  function automatic int wait_w(input int max_wait);
    return (max_wait > 0) ? $clog2(max_wait + 1) : 1;
  endfunction

endpackage : alu_arb_pkg
`default_nettype wire

// File: rtl/rr_arb2_aging.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2_aging
// Description : Two-way round-robin grant with an aging override for port 1.
//               Holds the last-grant pointer and the port 1 wait counter.
// Ports       : clk           - clock, rising edge
//               rst_n         - asynchronous active-low reset
//               req0_valid_i  - port 0 request
//               req1_valid_i  - port 1 request
//               grant0_o      - port 0 wins this cycle (only when requesting)
//               grant1_o      - port 1 wins this cycle (only when requesting)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2_aging #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0_valid_i,
  input  logic req1_valid_i,
  output logic grant0_o,
  output logic grant1_o
);
  import alu_arb_pkg::*;

  localparam int WAIT_W = wait_w(MAX_WAIT);

  logic              last_grant_q, last_grant_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              w_age;

  // Aging counter: counts consecutive cycles port 1 waits while valid.
  generate
    if (MAX_WAIT != 0) begin : g_age
      assign w_age = (wait_cnt_q == WAIT_W'(MAX_WAIT));

      always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!req1_valid_i || grant1_o) begin
          wait_cnt_d = '0;
        end else if (!w_age) begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
    end else begin : g_no_age
      assign w_age      = 1'b0;
      assign wait_cnt_d = '0;
    end
  endgenerate

  always_comb begin
    grant0_o = 1'b0;
    grant1_o = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      // A starved port 1 overrides the round-robin pointer.
      if (w_age || (last_grant_q == PORT_EX)) begin
        grant1_o = 1'b1;
      end else begin
        grant0_o = 1'b1;
      end
    end else if (req0_valid_i) begin
      grant0_o = 1'b1;
    end else if (req1_valid_i) begin
      grant1_o = 1'b1;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant0_o) begin
      last_grant_d = PORT_EX;
    end else if (grant1_o) begin
      last_grant_d = PORT_AUX;
    end
  end

  // Pointer resets to port 1 so port 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= PORT_AUX;
      wait_cnt_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

endmodule : rr_arb2_aging
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Shares one combinational ALU between the execute stage
//               (port 0) and an auxiliary sequencer (port 1). One operation
//               per cycle; results and flags return one cycle later. Owns
//               the architectural {C,Z,S} flag register, written only by
//               port 0 operations that request it.
// Ports       : clk, rst_n             - clock / async active-low reset
//               req0_* / req1_*        - request handshakes and payloads
//               rsp0_* / rsp1_*        - registered responses (1-cycle pulse)
//               alu_a/alu_b/alu_ctrl   - drive to the external ALU
//               alu_result/alu_flags   - sampled from the external ALU
//               flags_q                - architectural flag register
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int WIDTH    = 32,
  parameter int CTRL_W   = 5,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic              req0_flag_we,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic              rsp0_valid,
  output logic [WIDTH-1:0]  rsp0_result,
  output logic [2:0]        rsp0_flags,
  output logic              rsp1_valid,
  output logic [WIDTH-1:0]  rsp1_result,
  output logic [2:0]        rsp1_flags,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic [2:0]        alu_flags,
  output logic [2:0]        flags_q
);
  import alu_arb_pkg::*;

  logic             w_grant0, w_grant1;
  logic             w_xfer0, w_xfer1;

  logic             rsp0_valid_q, rsp0_valid_d;
  logic [WIDTH-1:0] rsp0_result_q, rsp0_result_d;
  logic [2:0]       rsp0_flags_q, rsp0_flags_d;
  logic             rsp1_valid_q, rsp1_valid_d;
  logic [WIDTH-1:0] rsp1_result_q, rsp1_result_d;
  logic [2:0]       rsp1_flags_q, rsp1_flags_d;
  logic [2:0]       flags_d;
  logic [2:0]       arch_flags_q;

  rr_arb2_aging #(
    .MAX_WAIT (MAX_WAIT)
  ) u_arb (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid_i (req0_valid),
    .req1_valid_i (req1_valid),
    .grant0_o     (w_grant0),
    .grant1_o     (w_grant1)
  );

  assign req0_ready = req0_valid & w_grant0;
  assign req1_ready = req1_valid & w_grant1;
  assign w_xfer0    = req0_ready;
  assign w_xfer1    = req1_ready;

  // ALU operands come from the winner; an idle ALU sees all zeros.
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = '0;
    if (w_xfer0) begin
      alu_a    = req0_a;
      alu_b    = req0_b;
      alu_ctrl = req0_ctrl;
    end else if (w_xfer1) begin
      alu_a    = req1_a;
      alu_b    = req1_b;
      alu_ctrl = req1_ctrl;
    end
  end

  // Winner captures the ALU outputs; the loser's response holds.
  always_comb begin
    rsp0_valid_d  = w_xfer0;
    rsp0_result_d = rsp0_result_q;
    rsp0_flags_d  = rsp0_flags_q;
    rsp1_valid_d  = w_xfer1;
    rsp1_result_d = rsp1_result_q;
    rsp1_flags_d  = rsp1_flags_q;
    flags_d       = arch_flags_q;
    if (w_xfer0) begin
      rsp0_result_d = alu_result;
      rsp0_flags_d  = alu_flags;
      if (req0_flag_we) begin
        flags_d = alu_flags;
      end
    end
    if (w_xfer1) begin
      rsp1_result_d = alu_result;
      rsp1_flags_d  = alu_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid_q  <= 1'b0;
      rsp0_result_q <= '0;
      rsp0_flags_q  <= '0;
      rsp1_valid_q  <= 1'b0;
      rsp1_result_q <= '0;
      rsp1_flags_q  <= '0;
      arch_flags_q  <= '0;
    end else begin
      rsp0_valid_q  <= rsp0_valid_d;
      rsp0_result_q <= rsp0_result_d;
      rsp0_flags_q  <= rsp0_flags_d;
      rsp1_valid_q  <= rsp1_valid_d;
      rsp1_result_q <= rsp1_result_d;
      rsp1_flags_q  <= rsp1_flags_d;
      arch_flags_q  <= flags_d;
    end
  end

  assign rsp0_valid  = rsp0_valid_q;
  assign rsp0_result = rsp0_result_q;
  assign rsp0_flags  = rsp0_flags_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp1_result = rsp1_result_q;
  assign rsp1_flags  = rsp1_flags_q;
  assign flags_q     = arch_flags_q;

endmodule : alu_arbiter
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter. Plays the external ALU
//               and keeps a transaction-level model of grants, responses,
//               flags and port 1 aging.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int WIDTH    = 32;
  localparam int CTRL_W   = 5;
  localparam int MAX_WAIT = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req0_valid = 1'b0, req0_ready;
  logic [WIDTH-1:0]  req0_a = '0, req0_b = '0;
  logic [CTRL_W-1:0] req0_ctrl = '0;
  logic              req0_flag_we = 1'b0;
  logic              req1_valid = 1'b0, req1_ready;
  logic [WIDTH-1:0]  req1_a = '0, req1_b = '0;
  logic [CTRL_W-1:0] req1_ctrl = '0;
  logic              rsp0_valid, rsp1_valid;
  logic [WIDTH-1:0]  rsp0_result, rsp1_result;
  logic [2:0]        rsp0_flags, rsp1_flags, flags_q;
  logic [WIDTH-1:0]  alu_a, alu_b, alu_result;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [2:0]        alu_flags;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(WIDTH), .CTRL_W(CTRL_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_ctrl(req0_ctrl), .req0_flag_we(req0_flag_we),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
    .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_flags(alu_flags), .flags_q(flags_q)
  );

  // Behavioural ALU: returns {flags[2:0], result[31:0]}
  function automatic logic [34:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] c);
    logic [32:0] wide;
    logic [31:0] r;
    logic [2:0]  f;
    logic        cy;
    cy = 1'b0;
    case (c)
      ALU_ADD:  begin wide = {1'b0, a} + {1'b0, b}; r = wide[31:0]; cy = wide[32]; end
      ALU_AND:  r = a & b;
      ALU_XOR:  r = a ^ b;
      ALU_SHL:  r = a << b[4:0];
      ALU_SHR:  r = a >> b[4:0];
      ALU_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
      ALU_DIFF: begin r = a - b; cy = (a < b); end
      default:  r = 32'h0;
    endcase
    f = '0;
    f[FLAG_C] = cy;
    f[FLAG_Z] = (r == 32'h0);
    f[FLAG_S] = r[31];
    return {f, r};
  endfunction

  always_comb {alu_flags, alu_result} = alu_model(alu_a, alu_b, alu_ctrl);

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Transaction-level model state
  int          m_last;      // port granted most recently
  int          m_wait;      // consecutive refused cycles of port 1
  bit          hold_last;   // pointer pinned by force
  logic        m_v0, m_v1;
  logic [31:0] m_r0, m_r1;
  logic [2:0]  m_f0, m_f1, m_flags;

  task automatic model_reset();
    m_last = 1; m_wait = 0;
    m_v0 = 0; m_v1 = 0; m_r0 = '0; m_r1 = '0;
    m_f0 = '0; m_f1 = '0; m_flags = '0;
  endtask

  task automatic drive_idle();
    req0_valid = 0; req0_a = '0; req0_b = '0; req0_ctrl = '0; req0_flag_we = 0;
    req1_valid = 0; req1_a = '0; req1_b = '0; req1_ctrl = '0;
  endtask

  task automatic check_rsp(input string pfx);
    chk_eq({pfx, "_rsp0_valid"}, rsp0_valid, m_v0);
    chk_eq({pfx, "_rsp0_result"}, rsp0_result, m_r0);
    chk_eq({pfx, "_rsp0_flags"}, rsp0_flags, m_f0);
    chk_eq({pfx, "_rsp1_valid"}, rsp1_valid, m_v1);
    chk_eq({pfx, "_rsp1_result"}, rsp1_result, m_r1);
    chk_eq({pfx, "_rsp1_flags"}, rsp1_flags, m_f1);
    chk_eq({pfx, "_flags_q"}, flags_q, m_flags);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    drive_idle();
    model_reset();
    #1;
    check_rsp("reset");
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  // One cycle, entered and left at a falling edge. g: -1 idle, else winner.
  task automatic step(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                      input logic [4:0] c0, input logic we0,
                      input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                      input logic [4:0] c1, output int g);
    logic [34:0] res;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_ctrl = c0; req0_flag_we = we0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_ctrl = c1;
    #1;
    if (v0 && v1)
      g = (MAX_WAIT != 0 && m_wait == MAX_WAIT) ? 1 : ((m_last == 1) ? 0 : 1);
    else if (v0) g = 0;
    else if (v1) g = 1;
    else g = -1;
    chk_eq("req0_ready", req0_ready, g == 0);
    chk_eq("req1_ready", req1_ready, g == 1);
    chk_eq("alu_a", alu_a, (g == 0) ? a0 : (g == 1) ? a1 : 32'h0);
    chk_eq("alu_b", alu_b, (g == 0) ? b0 : (g == 1) ? b1 : 32'h0);
    chk_eq("alu_ctrl", alu_ctrl, (g == 0) ? c0 : (g == 1) ? c1 : 5'h0);
    chk_eq("wait_cnt", dut.u_arb.wait_cnt_q, m_wait);
    @(posedge clk);
    m_v0 = (g == 0);
    m_v1 = (g == 1);
    if (g == 0) begin
      res = alu_model(a0, b0, c0);
      m_r0 = res[31:0]; m_f0 = res[34:32];
      if (we0) m_flags = res[34:32];
    end
    if (g == 1) begin
      res = alu_model(a1, b1, c1);
      m_r1 = res[31:0]; m_f1 = res[34:32];
    end
    if (g >= 0) m_last = g;
    if (hold_last) m_last = 1;
    if (!v1 || g == 1) m_wait = 0;
    else if (m_wait < MAX_WAIT) m_wait++;
    @(negedge clk);
    check_rsp("step");
  endtask

  task automatic idle_step(output int g);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, g);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 3))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return $urandom_range(0, 31);
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [4:0] rand_ctrl();
    case ($urandom_range(0, 6))
      0:       return ALU_ADD;
      1:       return ALU_AND;
      2:       return ALU_XOR;
      3:       return ALU_SHL;
      4:       return ALU_SHR;
      5:       return ALU_SRA;
      default: return ALU_DIFF;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    logic        pv0, pv1, pwe0;
    logic [31:0] pa0, pb0, pa1, pb1;
    logic [4:0]  pc0, pc1;

    hold_last = 0;
    model_reset();
    drive_idle();
    do_reset();

    // 1: single port 0 add
    step(1, 32'd5, 32'd7, ALU_ADD, 1, 0, 0, 0, 0, g);
    chk_eq("t1_grant", g, 0);
    chk_eq("t1_rsp0_valid", rsp0_valid, 1);
    chk_eq("t1_result", rsp0_result, 32'd12);
    chk_eq("t1_flags", rsp0_flags, 3'b000);
    chk_eq("t1_flags_q", flags_q, 3'b000);

    // 2: zero result sets Z; port 1 carry does not touch flags_q
    step(1, 32'hA5A5A5A5, 32'hA5A5A5A5, ALU_XOR, 1, 0, 0, 0, 0, g);
    chk_eq("t2_result", rsp0_result, 32'h0);
    chk_eq("t2_flags", rsp0_flags, 3'b010);
    chk_eq("t2_flags_q", flags_q, 3'b010);
    step(0, 0, 0, 0, 0, 1, 32'hFFFFFFFF, 32'd1, ALU_ADD, g);
    chk_eq("t2_rsp1_valid", rsp1_valid, 1);
    chk_eq("t2_rsp1_flags", rsp1_flags, 3'b110);
    chk_eq("t2_flags_q_held", flags_q, 3'b010);

    // 3: contention alternates starting with port 0
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 32'd3, 32'd9, ALU_AND, 0, 1, 32'd6, 32'd5, ALU_XOR, g);
      chk_eq("t3_seq", g, i % 2);
    end

    // 4: pin pointer so port 0 keeps winning; aging must rescue port 1
    do_reset();
    force dut.u_arb.last_grant_q = 1'b1;
    hold_last = 1;
    for (int i = 0; i < 5; i++) begin
      step(1, 32'd1, 32'd2, ALU_ADD, 0, 1, 32'd8, 32'd4, ALU_DIFF, g);
      chk_eq("t4_grant", g, (i == 4) ? 1 : 0);
    end
    release dut.u_arb.last_grant_q;
    hold_last = 0;
    chk_eq("t4_wait_clear", dut.u_arb.wait_cnt_q, 0);
    idle_step(g);

    // 5: reset right after a port 1 transfer
    step(0, 0, 0, 0, 0, 1, 32'd1, 32'd4, ALU_SHL, g);
    chk_eq("t5_rsp1_valid", rsp1_valid, 1);
    chk_eq("t5_result", rsp1_result, 32'd16);
    rst_n = 0;
    #1;
    chk_eq("t5_rst_valid", rsp1_valid, 0);
    chk_eq("t5_rst_result", rsp1_result, 0);
    chk_eq("t5_rst_flags_q", flags_q, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    idle_step(g);
    idle_step(g);

    // 6: idle cycles hold flags_q and drive zero to the ALU
    step(1, 32'hFFFFFFFF, 32'd1, ALU_ADD, 1, 0, 0, 0, 0, g);
    for (int i = 0; i < 3; i++) idle_step(g);
    chk_eq("t6_flags_q", flags_q, 3'b110);

    // Random traffic, payloads held until accepted
    pv0 = 0; pv1 = 0; pwe0 = 0;
    pa0 = '0; pb0 = '0; pc0 = '0; pa1 = '0; pb1 = '0; pc1 = '0;
    for (int n = 0; n < 400; n++) begin
      if (!pv0 && $urandom_range(0, 2) != 0) begin
        pv0 = 1; pa0 = rand_operand(); pb0 = rand_operand();
        pc0 = rand_ctrl(); pwe0 = $urandom_range(0, 1) != 0;
      end
      if (!pv1 && $urandom_range(0, 2) != 0) begin
        pv1 = 1; pa1 = rand_operand(); pb1 = rand_operand(); pc1 = rand_ctrl();
      end
      step(pv0, pa0, pb0, pc0, pwe0, pv1, pa1, pb1, pc1, g);
      if (g == 0) pv0 = 0;
      if (g == 1) pv1 = 0;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_alu_arbiter
`default_nettype wire
